dmem_mmio_responder: RTL and testbench

Data-memory responder for the 16-bit pipelined core's data port: it serves the core's MEM-stage accesses using its existing `dmemaddr`, `dmemwdata`, `dmemwrite`, `dmemread` and `dmemrdata` signals. It holds a word RAM and a memory-mapped I/O page containing an output port, a free-running timer and a transmit FIFO. The FIFO is drained by an external consumer over a valid/ready handshake. It sits at the top level beside the instruction memory, wired directly to the core.

---
 rtl/dmem_mmio_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//
// Data-memory responder for the 16-bit pipelined core's MEM stage. It holds a
// word-addressed RAM at the bottom of the address space and a small MMIO page:
//
//   0x0000 .. 2*RAM_WORDS-1 : RAM (word index = dmemaddr[log2(RAM_WORDS):1])
//   0xFF00                  : OUTPORT  (read/write)
//   0xFF02                  : TIMER    (read/write, free-running)
//   0xFF04                  : TXDATA   (write-only push into the TX FIFO, reads 0)
//   0xFF06                  : STATUS   (read: {overflow, count, full, empty};
//                                       write: bit5=1 clears overflow)
//
// Ports
//   clock       : all state updates on its rising edge
//   reset       : synchronous, active-high
//   dmemaddr    : byte address, bit 0 ignored
//   dmemwdata   : write data
//   dmemwrite   : write enable for this cycle
//   dmemread    : read enable for this cycle
//   dmemrdata   : combinational read data (0 when not reading / unmapped)
//   out_port    : OUTPORT register
//   tx_data     : TX FIFO head (0 while empty)
//   tx_valid    : TX FIFO non-empty
//   tx_ready    : consumer accepts the head this cycle
//   bad_access  : registered one-cycle pulse after an access to an unmapped address
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 128,  // power of two, at most 32768
    parameter int FIFO_DEPTH = 4     // power of two, 2..8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    output logic [15:0] out_port,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bad_access
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // MMIO word addresses (dmemaddr[15:1])
    localparam logic [14:0] WADDR_OUTPORT = 15'h7F80;  // 0xFF00
    localparam logic [14:0] WADDR_TIMER   = 15'h7F81;  // 0xFF02
    localparam logic [14:0] WADDR_TXDATA  = 15'h7F82;  // 0xFF04
    localparam logic [14:0] WADDR_STATUS  = 15'h7F83;  // 0xFF06

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [14:0]       word_addr;
    logic              sel_outport;
    logic              sel_timer;
    logic              sel_txdata;
    logic              sel_status;
    logic              mmio_hit;
    logic              ram_hit;
    logic              mapped;
    logic [RAM_AW-1:0] ram_idx;

    // Word accesses only: the byte-lane bit plays no part in decoding.
    logic unused_addr_lsb;
    assign unused_addr_lsb = dmemaddr[0];

    assign word_addr   = dmemaddr[15:1];
    assign sel_outport = (word_addr == WADDR_OUTPORT);
    assign sel_timer   = (word_addr == WADDR_TIMER);
    assign sel_txdata  = (word_addr == WADDR_TXDATA);
    assign sel_status  = (word_addr == WADDR_STATUS);
    assign mmio_hit    = sel_outport | sel_timer | sel_txdata | sel_status;

    // Compared at 32 bits so a 32768-word RAM (64 KiB) does not overflow the
    // bound. If the RAM is that large it overlaps the MMIO page; MMIO wins.
    assign ram_hit = !mmio_hit && ({16'd0, dmemaddr} < 32'(2 * RAM_WORDS));
    assign mapped  = ram_hit | mmio_hit;
    assign ram_idx = dmemaddr[RAM_AW:1];

    // -------------------------------------------------------------------------
    // Word RAM
    // -------------------------------------------------------------------------
    logic [15:0] ram_q [RAM_WORDS];

    // NOTE: storage arrays are deliberately left out of reset so they map onto
    // plain RAM/register-file cells; their contents are undefined until written.
    always_ff @(posedge clock) begin
        if (!reset && dmemwrite && ram_hit) begin
            ram_q[ram_idx] <= dmemwdata;
        end
    end

    // -------------------------------------------------------------------------
    // Registers: OUTPORT, TIMER, TX FIFO control, bad_access
    // -------------------------------------------------------------------------
    logic [15:0]      out_port_q, out_port_d;
    logic [15:0]      timer_q, timer_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             bad_access_q, bad_access_d;

    logic [15:0]      fifo_q [FIFO_DEPTH];

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push_ok;
    logic [15:0]      status_word;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // tx_valid comes straight from registered state, never from tx_ready.
    assign pop      = !fifo_empty && tx_ready;
    assign push_req = dmemwrite && sel_txdata;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!fifo_full || pop);

    // The count field is three bits wide; with an 8-deep FIFO the full flag
    // disambiguates the wrapped count of 8.
    assign status_word = {10'd0, overflow_q, 3'(count_q), fifo_full, fifo_empty};

    // NOTE: every combinational output gets a default at the top of the block so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        out_port_d   = out_port_q;
        timer_d      = timer_q + 16'd1;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        bad_access_d = (dmemread || dmemwrite) && !mapped;

        if (dmemwrite && sel_outport) begin
            out_port_d = dmemwdata;
        end

        // A timer write replaces this cycle's increment.
        if (dmemwrite && sel_timer) begin
            timer_d = dmemwdata;
        end

        // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH naturally.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Overflow only when a push is actually dropped; a STATUS write and a
        // TXDATA write cannot coincide since they are different addresses.
        if (dmemwrite && sel_status && dmemwdata[5]) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_port_q   <= '0;
            timer_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            bad_access_q <= 1'b0;
        end else begin
            out_port_q   <= out_port_d;
            timer_q      <= timer_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            bad_access_q <= bad_access_d;
        end
    end

    // FIFO entries are only observable through count/rd_ptr, which reset clears,
    // so a write landing in a reset cycle is harmless.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= dmemwdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_port   = out_port_q;
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 16'd0 : fifo_q[rd_ptr_q];
    assign bad_access = bad_access_q;

    // Zero-latency read mux; the old value is returned even when a write to the
    // same location happens at the end of this cycle.
    always_comb begin
        dmemrdata = 16'd0;
        if (dmemread) begin
            if (ram_hit) begin
                dmemrdata = ram_q[ram_idx];
            end else if (sel_outport) begin
                dmemrdata = out_port_q;
            end else if (sel_timer) begin
                dmemrdata = timer_q;
            end else if (sel_status) begin
                dmemrdata = status_word;
            end
            // TXDATA is write-only and unmapped addresses read as zero.
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dmem_mmio_responder (default parameters: 128-word RAM,
// 4-entry TX FIFO). A table of single-cycle bus vectors covers reset readback,
// RAM, OUTPORT and TIMER; hand-written sequences cover the FIFO, overflow,
// unmapped accesses and reset in mid-operation.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 2 units later, registered outputs 1 unit after the edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [15:0] out_port;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bad_access;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] A_OUTPORT = 16'hFF00;
    localparam logic [15:0] A_TIMER   = 16'hFF02;
    localparam logic [15:0] A_TXDATA  = 16'hFF04;
    localparam logic [15:0] A_STATUS  = 16'hFF06;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    dmem_mmio_responder dut (
        .clock      (clock),
        .reset      (reset),
        .dmemaddr   (dmemaddr),
        .dmemwdata  (dmemwdata),
        .dmemwrite  (dmemwrite),
        .dmemread   (dmemread),
        .dmemrdata  (dmemrdata),
        .out_port   (out_port),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .bad_access (bad_access)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic chk,
                                input logic [15:0] exp_rdata);
        vec_t v;
        v.rd        = rd;
        v.wr        = wr;
        v.addr      = addr;
        v.wdata     = wdata;
        v.chk       = chk;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
        dmemread  = rd;
        dmemwrite = wr;
        dmemaddr  = addr;
        dmemwdata = wdata;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic push(input logic [15:0] val);
        bus(1'b0, 1'b1, A_TXDATA, val);
        tick();
        idle();
    endtask

    task automatic read_status(input string name, input logic [15:0] exp);
        bus(1'b1, 1'b0, A_STATUS, 16'h0000);
        #2;
        check(name, dmemrdata, exp);
        tick();
        idle();
    endtask

    // Hold tx_ready high and expect the given entries in order, one per cycle.
    task automatic drain(input string name, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_q [4];
        exp_q[0] = e0;
        exp_q[1] = e1;
        exp_q[2] = e2;
        exp_q[3] = e3;
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("%s_valid%0d", name, k), 16'(tx_valid), 16'd1);
            check($sformatf("%s_data%0d", name, k), tx_data, exp_q[k]);
            tick();
        end
        tx_ready = 1'b0;
        check({name, "_empty_valid"}, 16'(tx_valid), 16'd0);
        check({name, "_empty_data"}, tx_data, 16'd0);
    endtask

    initial begin
        // Single-cycle bus vectors, applied right after reset deasserts.
        vecs.push_back(mk(1, 0, A_TIMER,   16'h0000, 1, 16'h0000));  // timer 0 first cycle
        vecs.push_back(mk(1, 0, A_STATUS,  16'h0000, 1, 16'h0001));  // empty
        vecs.push_back(mk(0, 1, 16'h0010,  16'h1234, 1, 16'h0000));  // write, no read -> 0
        vecs.push_back(mk(0, 1, 16'h00FE,  16'hBEEF, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 16'h0010,  16'h0000, 1, 16'h1234));
        vecs.push_back(mk(1, 0, 16'h00FE,  16'h0000, 1, 16'hBEEF));
        vecs.push_back(mk(1, 0, 16'h0011,  16'h0000, 1, 16'h1234));  // bit 0 ignored
        vecs.push_back(mk(0, 0, 16'h0010,  16'h0000, 1, 16'h0000));  // no read -> 0
        vecs.push_back(mk(1, 1, 16'h0010,  16'h5555, 1, 16'h1234));  // rd+wr: old value
        vecs.push_back(mk(1, 0, 16'h0010,  16'h0000, 1, 16'h5555));
        vecs.push_back(mk(0, 1, A_OUTPORT, 16'hC3C3, 0, 16'h0000));
        vecs.push_back(mk(1, 0, A_OUTPORT, 16'h0000, 1, 16'hC3C3));
        vecs.push_back(mk(1, 0, A_TXDATA,  16'h0000, 1, 16'h0000));  // write-only
        vecs.push_back(mk(0, 1, A_TIMER,   16'hFFFE, 0, 16'h0000));
        vecs.push_back(mk(1, 0, A_TIMER,   16'h0000, 1, 16'hFFFE));  // loaded value
        vecs.push_back(mk(1, 0, A_TIMER,   16'h0000, 1, 16'hFFFF));
        vecs.push_back(mk(1, 0, A_TIMER,   16'h0000, 1, 16'h0000));  // wrap
        vecs.push_back(mk(1, 0, A_TIMER,   16'h0000, 1, 16'h0001));

        // ---------------- reset defaults ----------------
        reset    = 1'b1;
        tx_ready = 1'b0;
        idle();
        tick();
        tick();
        check("rst_out_port", out_port, 16'h0000);
        check("rst_tx_valid", 16'(tx_valid), 16'd0);
        check("rst_tx_data", tx_data, 16'h0000);
        check("rst_bad_access", 16'(bad_access), 16'd0);
        check("rst_rdata_idle", dmemrdata, 16'h0000);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #2;
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rdata", i), dmemrdata, vecs[i].exp_rdata);
            end
            tick();
        end
        idle();
        check("out_port_reg", out_port, 16'hC3C3);

        // ---------------- FIFO fill and overflow ----------------
        push(16'h00A1);
        check("push1_valid", 16'(tx_valid), 16'd1);
        check("push1_data", tx_data, 16'h00A1);
        push(16'h00A2);
        push(16'h00A3);
        push(16'h00A4);
        read_status("status_full", 16'h0012);
        push(16'h00A5);
        read_status("status_overflow", 16'h0032);
        check("head_after_overflow", tx_data, 16'h00A1);
        drain("drainA", 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
        bus(1'b0, 1'b1, A_STATUS, 16'h0020);
        tick();
        idle();
        read_status("status_cleared", 16'h0001);

        // ---------------- full push + pop ----------------
        push(16'h00C1);
        push(16'h00C2);
        push(16'h00C3);
        push(16'h00C4);
        bus(1'b0, 1'b1, A_TXDATA, 16'h00B0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        idle();
        read_status("status_full_pushpop", 16'h0012);
        drain("drainC", 16'h00C2, 16'h00C3, 16'h00C4, 16'h00B0);

        // ---------------- unmapped accesses ----------------
        bus(1'b1, 1'b0, 16'h8000, 16'h0000);
        #2;
        check("unmapped_rdata", dmemrdata, 16'h0000);
        check("bad_before_edge", 16'(bad_access), 16'd0);
        tick();
        idle();
        check("bad_pulse_rd", 16'(bad_access), 16'd1);
        tick();
        check("bad_clear_rd", 16'(bad_access), 16'd0);
        bus(1'b0, 1'b1, 16'hFF08, 16'h5A5A);
        tick();
        idle();
        check("bad_pulse_wr", 16'(bad_access), 16'd1);
        check("unmapped_wr_no_effect", out_port, 16'hC3C3);
        tick();
        check("bad_clear_wr", 16'(bad_access), 16'd0);

        // ---------------- reset mid-operation ----------------
        push(16'h00D1);
        push(16'h00D2);
        check("pre_reset_valid", 16'(tx_valid), 16'd1);
        check("pre_reset_data", tx_data, 16'h00D1);
        reset    = 1'b1;
        tx_ready = 1'b1;
        bus(1'b0, 1'b1, A_TXDATA, 16'h00D3);  // reset must override push and pop
        tick();
        tx_ready = 1'b0;
        idle();
        check("midrst_valid", 16'(tx_valid), 16'd0);
        check("midrst_data", tx_data, 16'h0000);
        check("midrst_out_port", out_port, 16'h0000);
        reset = 1'b0;
        read_status("midrst_status", 16'h0001);
        check("post_rst_valid", 16'(tx_valid), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
